// File: rtl/fsm_error_accumulator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_tmr_pkg
//  Description : Shared types and saturating-increment helper for the FSM TMR
//                error accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
package fsm_tmr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } acc_state_t;

    localparam int c_SAT_MAX_W = 64;
    localparam int c_RUN_W     = 8;

    // Callers zero-extend into the 64-bit vector and truncate the result back.
    function automatic logic [c_SAT_MAX_W-1:0] sat_inc(
        input logic [c_SAT_MAX_W-1:0] val,
        input int                     width
    );
        logic [c_SAT_MAX_W-1:0] max_val;
        max_val = (width >= c_SAT_MAX_W) ? '1 : ((64'd1 << width) - 64'd1);
        return (val >= max_val) ? max_val : (val + 64'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fsm_error_accumulator_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Width-parameterised up-counter with enable, synchronous clear
//                and saturation at all-ones.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
    import fsm_tmr_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_next;

    assign w_next = WIDTH'(sat_inc(c_SAT_MAX_W'(r_cnt), WIDTH));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i) begin
            r_cnt <= w_next;
        end
    end

    assign cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: rtl/fsm_error_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_error_accumulator
//  Description : Accumulates one lane's comparator flags over a measurement
//                window and hands a frozen snapshot to readout via valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module fsm_error_accumulator
    import fsm_tmr_pkg::*;
#(
    parameter int CNT_WIDTH_G = 16,
    parameter int CYC_WIDTH_G = 32,
    parameter int LOCK_THR_G  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic                   clear_i,
    input  logic                   error_state_i,
    input  logic                   error_mismatch_i,
    output logic                   running_o,
    output logic                   snap_valid_o,
    input  logic                   snap_ready_i,
    output logic [CNT_WIDTH_G-1:0] mismatch_cnt_o,
    output logic [CNT_WIDTH_G-1:0] state_err_cnt_o,
    output logic [CYC_WIDTH_G-1:0] cycle_cnt_o,
    output logic [CYC_WIDTH_G-1:0] first_mm_cycle_o,
    output logic                   first_mm_valid_o,
    output logic                   lock_lost_o
);

    localparam logic [c_RUN_W-1:0] c_LOCK_THR = c_RUN_W'(LOCK_THR_G);

    acc_state_t             r_state;
    acc_state_t             w_state_next;
    logic                   w_zero;
    logic                   w_count;
    logic [c_RUN_W-1:0]     r_run;
    logic [c_RUN_W-1:0]     w_run_inc;
    logic [CYC_WIDTH_G-1:0] r_first_cycle;
    logic                   r_first_valid;
    logic                   r_lock_lost;

    // ------------------------------------------------------------------
    // Control FSM. w_zero wipes the whole window on clear and on RUN entry.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_zero       = clear_i;
        if (clear_i) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    // stop outranks start, so a simultaneous pair stays put
                    if (start_i && !stop_i) begin
                        w_state_next = RUN;
                        w_zero       = 1'b1;
                    end
                end
                RUN: begin
                    if (stop_i) begin
                        w_state_next = HOLD;
                    end
                end
                HOLD: begin
                    if (snap_ready_i) begin
                        w_state_next = IDLE;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_zero       = 1'b1;
                end
            endcase
        end
    end

    // The stop cycle still counts, so counting only depends on being in RUN.
    assign w_count = (r_state == RUN) && !clear_i;

    // ------------------------------------------------------------------
    // Saturating window counters
    // ------------------------------------------------------------------
    sat_counter #(.WIDTH(CNT_WIDTH_G)) u_mismatch_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (w_zero),
        .en_i    (w_count && error_mismatch_i),
        .cnt_o   (mismatch_cnt_o)
    );

    sat_counter #(.WIDTH(CNT_WIDTH_G)) u_state_err_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (w_zero),
        .en_i    (w_count && error_state_i),
        .cnt_o   (state_err_cnt_o)
    );

    sat_counter #(.WIDTH(CYC_WIDTH_G)) u_cycle_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (w_zero),
        .en_i    (w_count),
        .cnt_o   (cycle_cnt_o)
    );

    // ------------------------------------------------------------------
    // First-mismatch capture and consecutive-mismatch lock detection
    // ------------------------------------------------------------------
    assign w_run_inc = c_RUN_W'(sat_inc(c_SAT_MAX_W'(r_run), c_RUN_W));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_run         <= '0;
            r_first_cycle <= '0;
            r_first_valid <= 1'b0;
            r_lock_lost   <= 1'b0;
        end else if (w_zero) begin
            r_run         <= '0;
            r_first_cycle <= '0;
            r_first_valid <= 1'b0;
            r_lock_lost   <= 1'b0;
        end else if (w_count) begin
            if (error_mismatch_i) begin
                r_run <= w_run_inc;
                if (w_run_inc >= c_LOCK_THR) begin
                    r_lock_lost <= 1'b1;
                end
                // cycle_cnt_o is still the pre-increment value here
                if (!r_first_valid) begin
                    r_first_cycle <= cycle_cnt_o;
                    r_first_valid <= 1'b1;
                end
            end else begin
                r_run <= '0;
            end
        end
    end

    assign running_o        = (r_state == RUN);
    assign snap_valid_o     = (r_state == HOLD);
    assign first_mm_cycle_o = r_first_cycle;
    assign first_mm_valid_o = r_first_valid;
    assign lock_lost_o      = r_lock_lost;

endmodule
`default_nettype wire
